// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with flush, bubble insertion and debug counters
// Optional 2-entry skid buffer (registered in_ready) enabled by PIPE_STAGE_REG_SKID_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [STAT_W-1:0] stall_q, stall_d;
    logic [STAT_W-1:0] bubble_q, bubble_d;
    logic              in_fire;

`ifdef PIPE_STAGE_REG_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
    state_t            state_q, state_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            ctrl_d      = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        ctrl_d  = in_ctrl;
                        data_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_ready) begin
                        ctrl_d = in_ctrl;
                        data_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newcomer behind the held entry.
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = ST_TWO;
                    end else if (out_ready) begin
                        ctrl_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        ctrl_d  = skid_ctrl_q;
                        data_d  = skid_data_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    logic out_valid_q, out_valid_d;

    assign out_valid = out_valid_q;
    assign in_ready  = !out_valid_q | out_ready;
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            ctrl_d      = in_ctrl;
            data_d      = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end
`endif

    // Counters saturate at all-ones and are cleared only by reset.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + STAT_W'(1);
        end
        if (!out_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            data_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_ctrl   = ctrl_q;
    assign out_data   = data_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue-based model
module tb_pipe_stage_reg;
    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt, bubble_cnt;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_stall_cnt, s_bubble_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.STAT_W(2)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: an ordered queue of held entries plus raw event counts.
    logic [CTRL_W-1:0] mq_ctrl[$];
    logic [DATA_W-1:0] mq_data[$];
    logic [DATA_W-1:0] shown_data;
    int                m_stall, m_bubble;

    function automatic logic model_in_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
        return mq_ctrl.size() < 2;
`else
        return (mq_ctrl.size() == 0) || out_ready;
`endif
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq_ctrl.delete();
            mq_data.delete();
            shown_data = '0;
            m_stall    = 0;
            m_bubble   = 0;
        end else begin
            logic ir;
            ir = model_in_ready();
            if (mq_ctrl.size() > 0 && !out_ready) m_stall++;
            if (mq_ctrl.size() == 0) m_bubble++;
            if (flush) begin
                mq_ctrl.delete();
                mq_data.delete();
            end else begin
                if (mq_ctrl.size() > 0 && out_ready) begin
                    void'(mq_ctrl.pop_front());
                    void'(mq_data.pop_front());
                end
                if (in_valid && ir) begin
                    mq_ctrl.push_back(in_ctrl);
                    mq_data.push_back(in_data);
                end
            end
            if (mq_data.size() > 0) shown_data = mq_data[0];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic              ev;
        logic [CTRL_W-1:0] ec;
        ev = mq_ctrl.size() > 0;
        ec = ev ? mq_ctrl[0] : '0;
        check("out_valid",    128'(out_valid),    128'(ev));
        check("out_ctrl",     128'(out_ctrl),     128'(ec));
        check("out_data",     128'(out_data),     128'(shown_data));
        check("in_ready",     128'(in_ready),     128'(model_in_ready()));
        check("stall_cnt",    128'(stall_cnt),    128'(sat(m_stall, 65535)));
        check("bubble_cnt",   128'(bubble_cnt),   128'(sat(m_bubble, 65535)));
        check("s_out_valid",  128'(s_out_valid),  128'(ev));
        check("s_out_ctrl",   128'(s_out_ctrl),   128'(ec));
        check("s_out_data",   128'(s_out_data),   128'(shown_data));
        check("s_in_ready",   128'(s_in_ready),   128'(model_in_ready()));
        check("s_stall_cnt",  128'(s_stall_cnt),  128'(sat(m_stall, 3)));
        check("s_bubble_cnt", 128'(s_bubble_cnt), 128'(sat(m_bubble, 3)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0;
        repeat (3) step();
        check("rst_valid",  128'(out_valid),  128'(0));
        check("rst_stall",  128'(stall_cnt),  128'(0));
        check("rst_bubble", 128'(bubble_cnt), 128'(0));

        // Back-to-back stream 1,2,3 with downstream always ready
        reset = 1'b1; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 96'h1;
        step();
        check("t1_data1",  128'(out_data),   128'(1));
        check("t1_valid",  128'(out_valid),  128'(1));
        check("t1_ready",  128'(in_ready),   128'(1));
        in_data = 96'h2;
        step();
        check("t1_data2",  128'(out_data),   128'(2));
        in_data = 96'h3;
        step();
        check("t1_data3",  128'(out_data),   128'(3));
        check("t1_bubble", 128'(bubble_cnt), 128'(1));

        // Bubble insertion zeroes control
        in_ctrl = 8'hA5; in_data = 96'h4;
        step();
        check("t2_ctrl", 128'(out_ctrl), 128'(8'hA5));
        in_valid = 1'b0;
        step();
        check("t2_valid0", 128'(out_valid), 128'(0));
        check("t2_ctrl0",  128'(out_ctrl),  128'(0));
        check("t2_dhold",  128'(out_data),  128'(4));

        // Four-cycle stall with an entry held
        in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 96'h55; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
`ifndef PIPE_STAGE_REG_SKID_EN
        check("t3_inrdy0", 128'(in_ready), 128'(0));
`endif
        repeat (3) step();
        check("t3_stall4",  128'(stall_cnt),   128'(4));
        check("t3_sstall",  128'(s_stall_cnt), 128'(3));
        check("t3_data",    128'(out_data),    128'(8'h55));
        check("t3_ctrl",    128'(out_ctrl),    128'(8'h3C));

        // Flush beats a simultaneous input
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 96'hEE;
        step();
        check("t4_valid0", 128'(out_valid), 128'(0));
        check("t4_ctrl0",  128'(out_ctrl),  128'(0));
        check("t4_dhold",  128'(out_data),  128'(8'h55));
        check("t4_stall",  128'(stall_cnt), 128'(5));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

`ifdef PIPE_STAGE_REG_SKID_EN
        in_valid = 1'b1; in_ctrl = 8'h01; in_data = 96'h10; out_ready = 1'b0;
        step();
        in_ctrl = 8'h02; in_data = 96'h11;
        step();
        check("t5_inrdy0", 128'(in_ready), 128'(0));
        check("t5_first",  128'(out_data), 128'(8'h10));
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("t5_second", 128'(out_data),  128'(8'h11));
        check("t5_valid",  128'(out_valid), 128'(1));
        step();
`endif

        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 16) == 0;
            in_ctrl   = CTRL_W'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            step();
        end

        // Asynchronous reset in the middle of a saturated stall
        flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 96'h77; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("t6_ssat", 128'(s_stall_cnt), 128'(3));
        #1;
        reset = 1'b0;
        #1;
        check("t6_valid",   128'(out_valid),    128'(0));
        check("t6_ctrl",    128'(out_ctrl),     128'(0));
        check("t6_data",    128'(out_data),     128'(0));
        check("t6_sstall",  128'(s_stall_cnt),  128'(0));
        check("t6_sbubble", 128'(s_bubble_cnt), 128'(0));
        check("t6_stall",   128'(stall_cnt),    128'(0));
        #1;
        reset = 1'b1;
        step();
        check("t6_inrdy", 128'(in_ready), 128'(1));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
